// File: rtl/axi_lite_aes_regbank.sv
// ---------------------------------------------------------------------------
// axi_lite_aes_regbank
//   AXI4-Lite slave register bank that fronts an AES core.
//
//   Register map (index = byte address >> 2):
//     0 CTRL   : bit0 START (write-1 pulses start_o, reads 0), bit1 MODE (RW)
//     1 STATUS : bit0 BUSY (live busy_i), bit1 DONE (sticky, W1C)
//     2..N-1   : general RW words, byte-strobed; the core may overwrite them
//     >= N     : unmapped, SLVERR on both read and write
//
// Ports
//   s00_axi_aclk      : clock, everything on the rising edge
//   s00_axi_areset    : synchronous active-high reset
//   s00_axi_aw*/w*/b* : AXI4-Lite write address / data / response channels
//   s00_axi_ar*/r*    : AXI4-Lite read address / data channels
//   start_o           : one-cycle start pulse to the AES core
//   mode_o            : 0 = encrypt, 1 = decrypt
//   busy_i, done_i    : core busy level and completion pulse
//   regs_o            : registers 2..N-1 flattened, reg2 in the LSBs
//   core_wr_*         : full-word result write-back from the core
// ---------------------------------------------------------------------------
module axi_lite_aes_regbank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int C_NUM_REGS         = 8
) (
    input  logic                                        s00_axi_aclk,
    input  logic                                        s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]               s00_axi_awaddr,
    input  logic [2:0]                                  s00_axi_awprot,
    input  logic                                        s00_axi_awvalid,
    output logic                                        s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]               s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]             s00_axi_wstrb,
    input  logic                                        s00_axi_wvalid,
    output logic                                        s00_axi_wready,
    output logic [1:0]                                  s00_axi_bresp,
    output logic                                        s00_axi_bvalid,
    input  logic                                        s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]               s00_axi_araddr,
    input  logic [2:0]                                  s00_axi_arprot,
    input  logic                                        s00_axi_arvalid,
    output logic                                        s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]               s00_axi_rdata,
    output logic [1:0]                                  s00_axi_rresp,
    output logic                                        s00_axi_rvalid,
    input  logic                                        s00_axi_rready,
    output logic                                        start_o,
    output logic                                        mode_o,
    input  logic                                        busy_i,
    input  logic                                        done_i,
    output logic [(C_NUM_REGS-2)*C_S_AXI_DATA_WIDTH-1:0] regs_o,
    input  logic                                        core_wr_en_i,
    input  logic [$clog2(C_NUM_REGS)-1:0]               core_wr_idx_i,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]               core_wr_data_i
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = C_S_AXI_DATA_WIDTH / 8;
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam int CIW   = $clog2(C_NUM_REGS);

    // One extra bit so that C_NUM_REGS == 2**IDX_W is representable.
    localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W+1)'(C_NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [DW-1:0] strb_merge(
        input logic [DW-1:0] old_v,
        input logic [DW-1:0] new_v,
        input logic [SW-1:0] strb
    );
        logic [DW-1:0] res;
        res = old_v;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // Write-side holders and handshake state
    logic             aw_held_q, aw_held_d;
    logic [IDX_W-1:0] aw_idx_q,  aw_idx_d;
    logic             w_held_q,  w_held_d;
    logic [DW-1:0]    wdata_q,   wdata_d;
    logic [SW-1:0]    wstrb_q,   wstrb_d;
    logic             awready_q, awready_d;
    logic             wready_q,  wready_d;
    logic             bvalid_q,  bvalid_d;
    logic [1:0]       bresp_q,   bresp_d;

    // Read-side state
    logic             arready_q, arready_d;
    logic             rvalid_q,  rvalid_d;
    logic [DW-1:0]    rdata_q,   rdata_d;
    logic [1:0]       rresp_q,   rresp_d;

    // Control / status / general registers
    logic             mode_q,  mode_d;
    logic             done_q,  done_d;
    logic             start_q, start_d;
    logic [DW-1:0]    gp_q [2:C_NUM_REGS-1];
    logic [DW-1:0]    gp_d [2:C_NUM_REGS-1];

    logic             aw_take_s;
    logic             w_take_s;
    logic             ar_take_s;
    logic             commit_s;
    logic             wr_in_range_s;
    logic             wr_ctrl_s;
    logic             wr_stat_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic             rd_in_range_s;
    logic [DW-1:0]    rd_word_s;
    logic             unused_ok_s;

    // Protection bits and sub-word address bits carry no meaning here.
    assign unused_ok_s = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // Handshake and decode terms shared by the next-state logic
    always_comb begin
        aw_take_s     = s00_axi_awvalid && awready_q;
        w_take_s      = s00_axi_wvalid && wready_q;
        ar_take_s     = s00_axi_arvalid && arready_q;
        commit_s      = aw_held_q && w_held_q;
        wr_in_range_s = ({1'b0, aw_idx_q} < NUM_REGS_L);
        wr_ctrl_s     = commit_s && (aw_idx_q == IDX_W'(0));
        wr_stat_s     = commit_s && (aw_idx_q == IDX_W'(1));
        rd_idx_s      = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
        rd_in_range_s = ({1'b0, rd_idx_s} < NUM_REGS_L);
    end

    // Read mux over current register values (a coincident commit is not yet visible)
    always_comb begin
        rd_word_s = {DW{1'b0}};
        if (rd_idx_s == IDX_W'(0)) begin
            rd_word_s[1] = mode_q;
        end else if (rd_idx_s == IDX_W'(1)) begin
            rd_word_s[1:0] = {done_q, busy_i};
        end else begin
            for (int i = 2; i < C_NUM_REGS; i++) begin
                rd_word_s = (rd_idx_s == IDX_W'(i)) ? gp_q[i] : rd_word_s;
            end
        end
    end

    // Next-state logic for channels and registers
    always_comb begin
        // Commit needs aw_held_q, which forces awready_q low, so take and commit never overlap.
        aw_held_d = commit_s ? 1'b0 : (aw_take_s ? 1'b1 : aw_held_q);
        aw_idx_d  = aw_take_s ? s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2] : aw_idx_q;
        w_held_d  = commit_s ? 1'b0 : (w_take_s ? 1'b1 : w_held_q);
        wdata_d   = w_take_s ? s00_axi_wdata : wdata_q;
        wstrb_d   = w_take_s ? s00_axi_wstrb : wstrb_q;

        bvalid_d  = commit_s ? 1'b1 : ((bvalid_q && s00_axi_bready) ? 1'b0 : bvalid_q);
        bresp_d   = commit_s ? (wr_in_range_s ? RESP_OKAY : RESP_SLVERR) : bresp_q;
        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;

        rvalid_d  = ar_take_s ? 1'b1 : ((rvalid_q && s00_axi_rready) ? 1'b0 : rvalid_q);
        rdata_d   = ar_take_s ? (rd_in_range_s ? rd_word_s : {DW{1'b0}}) : rdata_q;
        rresp_d   = ar_take_s ? (rd_in_range_s ? RESP_OKAY : RESP_SLVERR) : rresp_q;
        arready_d = !rvalid_d;

        // START is dropped while the core is busy; MODE is still written.
        start_d   = wr_ctrl_s && wstrb_q[0] && wdata_q[0] && !busy_i;
        mode_d    = (wr_ctrl_s && wstrb_q[0]) ? wdata_q[1] : mode_q;
        // A completion pulse beats a simultaneous W1C clear.
        done_d    = done_i ? 1'b1 :
                    ((wr_stat_s && wstrb_q[0] && wdata_q[1]) ? 1'b0 : done_q);

        // Core write-back wins over an AXI commit to the same register.
        for (int i = 2; i < C_NUM_REGS; i++) begin
            if (core_wr_en_i && (core_wr_idx_i == CIW'(i))) begin
                gp_d[i] = core_wr_data_i;
            end else if (commit_s && (aw_idx_q == IDX_W'(i))) begin
                gp_d[i] = strb_merge(gp_q[i], wdata_q, wstrb_q);
            end else begin
                gp_d[i] = gp_q[i];
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= {IDX_W{1'b0}};
            w_held_q  <= 1'b0;
            wdata_q   <= {DW{1'b0}};
            wstrb_q   <= {SW{1'b0}};
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= {DW{1'b0}};
            rresp_q   <= 2'b00;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            for (int i = 2; i < C_NUM_REGS; i++) begin
                gp_q[i] <= {DW{1'b0}};
            end
        end else begin
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            start_q   <= start_d;
            for (int i = 2; i < C_NUM_REGS; i++) begin
                gp_q[i] <= gp_d[i];
            end
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = rresp_q;
    assign start_o         = start_q;
    assign mode_o          = mode_q;

    for (genvar g = 2; g < C_NUM_REGS; g++) begin : g_flat
        assign regs_o[(g-2)*DW +: DW] = gp_q[g];
    end

endmodule

// File: tb/tb_axi_lite_aes_regbank.sv
module tb_axi_lite_aes_regbank;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NR  = 6;
    localparam int CIW = 3;

    logic                 clk;
    logic                 areset;
    logic [AW-1:0]        awaddr;
    logic [2:0]           awprot;
    logic                 awvalid;
    logic                 awready;
    logic [DW-1:0]        wdata;
    logic [3:0]           wstrb;
    logic                 wvalid;
    logic                 wready;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;
    logic [AW-1:0]        araddr;
    logic [2:0]           arprot;
    logic                 arvalid;
    logic                 arready;
    logic [DW-1:0]        rdata;
    logic [1:0]           rresp;
    logic                 rvalid;
    logic                 rready;
    logic                 start_o;
    logic                 mode_o;
    logic                 busy_i;
    logic                 done_i;
    logic [(NR-2)*DW-1:0] regs_o;
    logic                 core_wr_en;
    logic [CIW-1:0]       core_wr_idx;
    logic [DW-1:0]        core_wr_data;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;

    // Scoreboards: expected write responses and expected {rresp, rdata}
    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    // Bench-side register model
    logic [DW-1:0] exp_regs [0:7];
    logic          exp_mode;
    logic          exp_done;

    axi_lite_aes_regbank #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_NUM_REGS(NR)
    ) dut (
        .s00_axi_aclk(clk),
        .s00_axi_areset(areset),
        .s00_axi_awaddr(awaddr),
        .s00_axi_awprot(awprot),
        .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata(wdata),
        .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid),
        .s00_axi_wready(wready),
        .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid),
        .s00_axi_bready(bready),
        .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot),
        .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata(rdata),
        .s00_axi_rresp(rresp),
        .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready),
        .start_o(start_o),
        .mode_o(mode_o),
        .busy_i(busy_i),
        .done_i(done_i),
        .regs_o(regs_o),
        .core_wr_en_i(core_wr_en),
        .core_wr_idx_i(core_wr_idx),
        .core_wr_data_i(core_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles in which start_o is high, sampled away from the active edge
    always @(negedge clk) begin
        if (start_o === 1'b1) start_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [3:0] s);
        logic [DW-1:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [(NR-2)*DW-1:0] exp_flat();
        logic [(NR-2)*DW-1:0] f;
        for (int i = 2; i < NR; i++) f[(i-2)*DW +: DW] = exp_regs[i];
        return f;
    endfunction

    function automatic logic [33:0] exp_read(input logic [AW-1:0] a);
        int idx;
        idx = int'(a[AW-1:2]);
        if (idx >= NR) return {2'b10, 32'h0000_0000};
        if (idx == 0)  return {2'b00, 30'd0, exp_mode, 1'b0};
        if (idx == 1)  return {2'b00, 30'd0, exp_done, busy_i};
        return {2'b00, exp_regs[idx]};
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a[AW-1:2]);
        if (idx == 0) begin
            if (s[0]) exp_mode = d[1];
        end else if (idx == 1) begin
            if (s[0] && d[1]) exp_done = 1'b0;
        end else if (idx < NR) begin
            exp_regs[idx] = merge(exp_regs[idx], d, s);
        end
    endtask

    function automatic logic [1:0] exp_bresp(input logic [AW-1:0] a);
        return (int'(a[AW-1:2]) >= NR) ? 2'b10 : 2'b00;
    endfunction

    task automatic wait_b();
        int cyc;
        logic [1:0] e;
        cyc = 0;
        while (bvalid !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        check("bvalid_seen", bvalid, 1'b1);
        e = (bq.size() > 0) ? bq.pop_front() : 2'b11;
        check("bresp", bresp, e);
    endtask

    task automatic wait_r();
        int cyc;
        logic [33:0] e;
        cyc = 0;
        while (rvalid !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        check("rvalid_seen", rvalid, 1'b1);
        e = (rq.size() > 0) ? rq.pop_front() : 34'h3_FFFF_FFFF;
        check("rdata", rdata, e[31:0]);
        check("rresp", rresp, e[33:32]);
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        int cyc;
        logic aw_hs, w_hs;
        bq.push_back(exp_bresp(a));
        model_write(a, d, s);
        @(negedge clk);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
        cyc = 0;
        while ((awvalid || wvalid) && cyc < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(negedge clk);
            cyc++;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
        end
        check("aw_w_accepted", {awvalid, wvalid}, 2'b00);
        awvalid = 1'b0; wvalid = 1'b0;
        wait_b();
    endtask

    task automatic axi_read(input logic [AW-1:0] a);
        int cyc;
        logic hs;
        rq.push_back(exp_read(a));
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        cyc = 0;
        hs = 1'b0;
        while (!hs && cyc < 50) begin
            hs = arready;
            @(negedge clk);
            cyc++;
        end
        check("ar_accepted", hs, 1'b1);
        arvalid = 1'b0;
        wait_r();
    endtask

    // Write whose commit edge coincides with a side event:
    // kind 0 = done_i pulse, 1 = core write idx 3, 2 = read of the same address
    task automatic write_side(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                              input int kind);
        if (kind == 2) rq.push_back(exp_read(a));
        bq.push_back(exp_bresp(a));
        model_write(a, d, s);
        if (kind == 0) exp_done = 1'b1;
        if (kind == 1) exp_regs[3] = 32'hDEAD_BEEF;
        @(negedge clk);
        check("side_awready", awready, 1'b1);
        check("side_wready", wready, 1'b1);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        if (kind == 0) done_i = 1'b1;
        if (kind == 1) begin core_wr_en = 1'b1; core_wr_idx = 3'd3; core_wr_data = 32'hDEAD_BEEF; end
        if (kind == 2) begin
            check("side_arready", arready, 1'b1);
            araddr = a; arvalid = 1'b1;
        end
        @(negedge clk);
        done_i = 1'b0; core_wr_en = 1'b0; arvalid = 1'b0;
        if (kind == 2) wait_r();
        wait_b();
    endtask

    initial begin
        areset = 1'b1;
        awaddr = '0; awprot = 3'b000; awvalid = 1'b0;
        wdata = '0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b1;
        busy_i = 1'b0; done_i = 1'b0;
        core_wr_en = 1'b0; core_wr_idx = 3'd0; core_wr_data = '0;
        for (int i = 0; i < 8; i++) exp_regs[i] = 32'h0;
        exp_mode = 1'b0; exp_done = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", awready, 1'b0);
        check("rst_wready", wready, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_start", start_o, 1'b0);
        check("rst_mode", mode_o, 1'b0);
        check("rst_regs", regs_o, 128'h0);
        areset = 1'b0;
        @(negedge clk);
        check("post_rst_awready", awready, 1'b1);
        check("post_rst_wready", wready, 1'b1);
        check("post_rst_arready", arready, 1'b1);

        // Basic write/read
        axi_write(5'h08, 32'hA5A5_A5A5, 4'hF);
        axi_read(5'h08);

        // Byte strobes
        axi_write(5'h0C, 32'h1122_3344, 4'hF);
        axi_write(5'h0C, 32'hFFFF_FFFF, 4'h5);
        check("strb_model", exp_regs[3], 32'h11FF_33FF);
        axi_read(5'h0C);
        check("regs_flat", regs_o, exp_flat());

        // W three cycles ahead of AW, B held with bready low
        bready = 1'b0;
        model_write(5'h10, 32'h0BAD_F00D, 4'hF);
        @(negedge clk);
        check("w_early_wready", wready, 1'b1);
        wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        check("w_early_wready_drop", wready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("w_early_awready", awready, 1'b1);
        awaddr = 5'h10; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("w_early_bvalid_not_yet", bvalid, 1'b0);
        @(negedge clk);
        check("w_early_bvalid", bvalid, 1'b1);
        check("w_early_bresp", bresp, 2'b00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b_hold", bvalid, 1'b1);
            check("b_hold_awready", awready, 1'b0);
        end
        bready = 1'b1;
        @(negedge clk);
        check("b_release", bvalid, 1'b0);
        check("b_release_awready", awready, 1'b1);
        axi_read(5'h10);

        // START pulse and MODE
        begin
            int s0;
            s0 = start_cnt;
            axi_write(5'h00, 32'h0000_0003, 4'hF);
            @(negedge clk);
            check("start_pulse_count", start_cnt - s0, 1);
            check("mode_o", mode_o, 1'b1);
            busy_i = 1'b1;
            s0 = start_cnt;
            axi_write(5'h00, 32'h0000_0003, 4'hF);
            @(negedge clk);
            check("start_busy_dropped", start_cnt - s0, 0);
            axi_read(5'h00);
            axi_read(5'h04);
            busy_i = 1'b0;
        end

        // DONE sticky, W1C, and set-wins
        @(negedge clk);
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        exp_done = 1'b1;
        axi_read(5'h04);
        axi_write(5'h04, 32'h0000_0002, 4'hF);
        axi_read(5'h04);
        write_side(5'h04, 32'h0000_0002, 4'hF, 0);
        axi_read(5'h04);

        // Unmapped index and core-wins collision
        axi_write(5'h18, 32'h1234_5678, 4'hF);
        check("oob_regs_unchanged", regs_o, exp_flat());
        axi_read(5'h18);
        write_side(5'h0C, 32'h0102_0304, 4'hF, 1);
        axi_read(5'h0C);

        // Read coincident with commit sees the old value
        write_side(5'h08, 32'h5A5A_0000, 4'hC, 2);
        axi_read(5'h08);

        // Core write-back: ignored indices, then a valid one
        @(negedge clk);
        core_wr_en = 1'b1; core_wr_data = 32'hFFFF_FFFF; core_wr_idx = 3'd1;
        @(negedge clk);
        core_wr_idx = 3'd0;
        @(negedge clk);
        core_wr_idx = 3'd7;
        @(negedge clk);
        core_wr_idx = 3'd5; core_wr_data = 32'hCAFE_F00D;
        exp_regs[5] = 32'hCAFE_F00D;
        @(negedge clk);
        core_wr_en = 1'b0;
        check("core_regs_flat", regs_o, exp_flat());
        axi_read(5'h04);
        axi_read(5'h00);
        axi_read(5'h14);

        // Reset with a data beat held aborts it
        @(negedge clk);
        wdata = 32'h7777_7777; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        check("mid_wready_held", wready, 1'b0);
        areset = 1'b1;
        for (int i = 0; i < 8; i++) exp_regs[i] = 32'h0;
        exp_mode = 1'b0; exp_done = 1'b0;
        @(negedge clk);
        check("mid_rst_wready", wready, 1'b0);
        check("mid_rst_awready", awready, 1'b0);
        check("mid_rst_arready", arready, 1'b0);
        check("mid_rst_regs", regs_o, 128'h0);
        check("mid_rst_mode", mode_o, 1'b0);
        areset = 1'b0;
        @(negedge clk);
        check("mid_post_awready", awready, 1'b1);
        check("mid_post_wready", wready, 1'b1);
        awaddr = 5'h14; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_no_stale_commit", bvalid, 1'b0);
        bq.push_back(2'b00);
        model_write(5'h14, 32'h0000_0042, 4'hF);
        wdata = 32'h0000_0042; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        wait_b();
        axi_read(5'h14);
        axi_read(5'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
